// File: rtl/spi_rgb_target.sv
// SPI mode-0 target exposing three RGB duty registers and an ID byte,
// with a built-in 8-bit PWM generator driving the LED channels.
module spi_rgb_target #(
  parameter int unsigned PWM_DIV  = 4,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sck,
  input  logic spi_ssn,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic pwm_red,
  output logic pwm_green,
  output logic pwm_blue,
  output logic wr_strobe
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  localparam logic [7:0] DIV_M1 = 8'(PWM_DIV - 1);

  logic [2:0] sck_q;
  logic [2:0] ssn_q;
  logic [1:0] mosi_q;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_in;
  logic [7:0] cmd;
  logic [7:0] shifter;
  logic [7:0] duty_r, duty_g, duty_b;

  logic       sck_rise, sck_fall;
  logic       ssn_rise, ssn_fall;
  logic [7:0] next_byte;
  logic [7:0] rd_val;
  logic       next_ok;
  logic       cmd_ok;

  // ssn flops reset low so a frame already under way at reset never
  // produces a falling edge; only a fresh ssn high-then-low starts one
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= '0;
      ssn_q  <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      ssn_q  <= {ssn_q[1:0], spi_ssn};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign ssn_rise  = ssn_q[1] & ~ssn_q[2];
  assign ssn_fall  = ~ssn_q[1] & ssn_q[2];
  assign next_byte = {shift_in[6:0], mosi_q[1]};
  assign next_ok   = (next_byte[6:2] == 5'd0);
  assign cmd_ok    = (cmd[6:2] == 5'd0);

  always_comb begin
    rd_val = 8'h00;
    unique case (next_byte[1:0])
      2'd0:    rd_val = duty_r;
      2'd1:    rd_val = duty_g;
      2'd2:    rd_val = duty_b;
      default: rd_val = ID_VALUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_in    <= '0;
      cmd         <= '0;
      shifter     <= '0;
      duty_r      <= '0;
      duty_g      <= '0;
      duty_b      <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_strobe   <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (ssn_rise) begin
        state       <= IDLE;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ssn_fall) begin
              state       <= CMD;
              bit_cnt     <= '0;
              spi_miso    <= 1'b0;
              spi_miso_oe <= 1'b1;
            end
          end
          CMD: begin
            if (sck_rise) begin
              shift_in <= next_byte;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                cmd     <= next_byte;
                shifter <= next_ok ? rd_val : 8'h00;
                state   <= DATA;
              end
            end
          end
          DATA: begin
            if (sck_fall) begin
              spi_miso <= shifter[7];
              shifter  <= {shifter[6:0], 1'b0};
            end
            if (sck_rise) begin
              shift_in <= next_byte;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state    <= DONE;
                spi_miso <= 1'b0;
                if (!cmd[7] && cmd_ok) begin
                  unique case (cmd[1:0])
                    2'd0:    duty_r <= next_byte;
                    2'd1:    duty_g <= next_byte;
                    2'd2:    duty_b <= next_byte;
                    default: ;
                  endcase
                  wr_strobe <= (cmd[1:0] != 2'd3);
                end
              end
            end
          end
          default: spi_miso <= 1'b0;
        endcase
      end
    end
  end

  logic [7:0] presc;
  logic [7:0] cnt;
  logic [7:0] sh_r, sh_g, sh_b;

  // shadows only follow the duty registers at the 255->0 wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      cnt       <= '0;
      sh_r      <= '0;
      sh_g      <= '0;
      sh_b      <= '0;
      pwm_red   <= 1'b0;
      pwm_green <= 1'b0;
      pwm_blue  <= 1'b0;
    end else begin
      if (presc == DIV_M1) begin
        presc <= '0;
        cnt   <= cnt + 8'd1;
        if (cnt == 8'hFF) begin
          sh_r <= duty_r;
          sh_g <= duty_g;
          sh_b <= duty_b;
        end
      end else begin
        presc <= presc + 8'd1;
      end
      pwm_red   <= (cnt < sh_r);
      pwm_green <= (cnt < sh_g);
      pwm_blue  <= (cnt < sh_b);
    end
  end

endmodule

// File: tb/tb_spi_rgb_target.sv
// Randomized bench for spi_rgb_target against a register-level model.
module tb_spi_rgb_target;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_ssn = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe;
  logic pwm_red, pwm_green, pwm_blue;
  logic wr_strobe;

  int tests = 0;
  int fails = 0;
  int strobes = 0;

  logic [7:0] m_duty [3];
  localparam logic [7:0] M_ID = 8'hA5;

  spi_rgb_target #(.PWM_DIV(4), .ID_VALUE(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .spi_sck(spi_sck),
    .spi_ssn(spi_ssn),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .pwm_red(pwm_red),
    .pwm_green(pwm_green),
    .pwm_blue(pwm_blue),
    .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe) strobes++;

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    half();
    spi_sck = 1'b1;
    r = spi_miso;
    half();
    spi_sck = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] c, input logic [7:0] d,
                           input int ndata, output logic [7:0] rd,
                           output logic oe_mid);
    logic [15:0] w;
    logic b;
    w = {c, d};
    rd = 8'h00;
    oe_mid = 1'b0;
    spi_ssn = 1'b0;
    half();
    for (int i = 0; i < 8 + ndata; i++) begin
      spi_bit(w[15-i], b);
      if (i >= 8) rd = {rd[6:0], b};
      if (i == 4) oe_mid = spi_miso_oe;
    end
    half();
    spi_ssn = 1'b1;
    spi_mosi = 1'b0;
    half();
    half();
  endtask

  task automatic measure(input int n, output int hr, output int hg,
                         output int hb);
    hr = 0; hg = 0; hb = 0;
    repeat (n) begin
      @(negedge clk);
      hr += int'(pwm_red);
      hg += int'(pwm_green);
      hb += int'(pwm_blue);
    end
  endtask

  task automatic test_reset();
    int hi, lo_miso, lo_oe;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({spi_miso, spi_miso_oe, pwm_red, pwm_green, pwm_blue, wr_strobe}
        !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {spi_miso, spi_miso_oe, pwm_red, pwm_green, pwm_blue,
                wr_strobe});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) m_duty[i] = 8'h00;
    strobes = 0;
    hi = 0; lo_miso = 0; lo_oe = 0;
    repeat (2000) begin
      @(negedge clk);
      hi += int'(pwm_red) + int'(pwm_green) + int'(pwm_blue);
      lo_miso += int'(spi_miso);
      lo_oe += int'(spi_miso_oe);
    end
    tests++;
    if (hi !== 0) begin
      fails++;
      $display("FAIL idle_pwm: got %0d high clks expected 0", hi);
    end
    tests++;
    if ((lo_miso + lo_oe) !== 0) begin
      fails++;
      $display("FAIL idle_miso: got %0d active clks expected 0",
               lo_miso + lo_oe);
    end
    tests++;
    if (strobes !== 0) begin
      fails++;
      $display("FAIL idle_strobe: got %0d expected 0", strobes);
    end
  endtask

  task automatic test_write_red();
    logic [7:0] rd;
    logic oe;
    int hr, hg, hb, s0;
    s0 = strobes;
    spi_frame(8'h00, 8'h40, 8, rd, oe);
    m_duty[0] = 8'h40;
    tests++;
    if (strobes - s0 !== 1) begin
      fails++;
      $display("FAIL red_strobe: got %0d expected 1", strobes - s0);
    end
    repeat (1100) @(negedge clk);
    measure(1024, hr, hg, hb);
    tests++;
    if (hr !== 256) begin
      fails++;
      $display("FAIL red_pwm: got %0d expected 256", hr);
    end
  endtask

  task automatic test_read();
    logic [7:0] rd;
    logic oe;
    spi_frame(8'h83, 8'h00, 8, rd, oe);
    tests++;
    if (rd !== M_ID) begin
      fails++;
      $display("FAIL read_id: got %h expected %h", rd, M_ID);
    end
    tests++;
    if (oe !== 1'b1) begin
      fails++;
      $display("FAIL miso_oe: got %b expected 1", oe);
    end
    spi_frame(8'h80, 8'h00, 8, rd, oe);
    tests++;
    if (rd !== m_duty[0]) begin
      fails++;
      $display("FAIL read_red: got %h expected %h", rd, m_duty[0]);
    end
  endtask

  task automatic test_id_write();
    logic [7:0] rd;
    logic oe;
    int s0;
    s0 = strobes;
    spi_frame(8'h03, 8'h55, 8, rd, oe);
    tests++;
    if (strobes !== s0) begin
      fails++;
      $display("FAIL id_write_strobe: got %0d expected 0", strobes - s0);
    end
    spi_frame(8'h83, 8'h00, 8, rd, oe);
    tests++;
    if (rd !== M_ID) begin
      fails++;
      $display("FAIL id_after_write: got %h expected %h", rd, M_ID);
    end
  endtask

  task automatic test_invalid();
    logic [7:0] rd;
    logic oe;
    int s0;
    s0 = strobes;
    spi_frame(8'h04, 8'hFF, 8, rd, oe);
    tests++;
    if (strobes !== s0) begin
      fails++;
      $display("FAIL invalid_strobe: got %0d expected 0", strobes - s0);
    end
    spi_frame(8'h84, 8'h00, 8, rd, oe);
    tests++;
    if (rd !== 8'h00) begin
      fails++;
      $display("FAIL invalid_read: got %h expected 00", rd);
    end
    spi_frame(8'h80, 8'h00, 8, rd, oe);
    tests++;
    if (rd !== m_duty[0]) begin
      fails++;
      $display("FAIL invalid_keeps_red: got %h expected %h", rd, m_duty[0]);
    end
  endtask

  task automatic test_abort_blue();
    logic [7:0] rd;
    logic oe;
    int s0, hr, hg, hb;
    s0 = strobes;
    spi_frame(8'h02, 8'hFF, 5, rd, oe);
    tests++;
    if (strobes !== s0) begin
      fails++;
      $display("FAIL abort_strobe: got %0d expected 0", strobes - s0);
    end
    spi_frame(8'h82, 8'h00, 8, rd, oe);
    tests++;
    if (rd !== m_duty[2]) begin
      fails++;
      $display("FAIL abort_blue: got %h expected %h", rd, m_duty[2]);
    end
    spi_frame(8'h02, 8'hFF, 8, rd, oe);
    m_duty[2] = 8'hFF;
    repeat (1100) @(negedge clk);
    measure(1024, hr, hg, hb);
    tests++;
    if (hb !== 1020) begin
      fails++;
      $display("FAIL blue_full: got %0d expected 1020", hb);
    end
  endtask

  task automatic test_random();
    logic [7:0] c, d, rd, exp;
    logic oe;
    logic rw;
    logic [1:0] a;
    logic [4:0] bad;
    int s0, es, hr, hg, hb;
    for (int n = 0; n < 10; n++) begin
      rw = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      bad = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      d = 8'($urandom);
      c = {rw, bad, a};
      exp = 8'h00;
      if (bad == 5'd0) exp = (a == 2'd3) ? M_ID : m_duty[a];
      es = (!rw && bad == 5'd0 && a != 2'd3) ? 1 : 0;
      s0 = strobes;
      spi_frame(c, d, 8, rd, oe);
      if (es == 1) m_duty[a] = d;
      tests++;
      if (strobes - s0 !== es) begin
        fails++;
        $display("FAIL rand_strobe cmd=%h: got %0d expected %0d",
                 c, strobes - s0, es);
      end
      if (rw) begin
        tests++;
        if (rd !== exp) begin
          fails++;
          $display("FAIL rand_read cmd=%h: got %h expected %h", c, rd, exp);
        end
      end
    end
    repeat (1100) @(negedge clk);
    measure(1024, hr, hg, hb);
    tests++;
    if ({hr, hg, hb} !== {int'(m_duty[0]) * 4, int'(m_duty[1]) * 4,
                          int'(m_duty[2]) * 4}) begin
      fails++;
      $display("FAIL rand_pwm: got %0d/%0d/%0d expected %0d/%0d/%0d",
               hr, hg, hb, m_duty[0] * 4, m_duty[1] * 4, m_duty[2] * 4);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w;
    logic [7:0] rd;
    logic oe, b;
    int s0;
    w = {8'h01, 8'hFF};
    spi_ssn = 1'b0;
    half();
    for (int i = 0; i < 4; i++) spi_bit(w[15-i], b);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) m_duty[i] = 8'h00;
    s0 = strobes;
    for (int i = 4; i < 16; i++) spi_bit(w[15-i], b);
    half();
    spi_ssn = 1'b1;
    half();
    half();
    tests++;
    if (strobes !== s0) begin
      fails++;
      $display("FAIL midframe_strobe: got %0d expected 0", strobes - s0);
    end
    spi_frame(8'h81, 8'h00, 8, rd, oe);
    tests++;
    if (rd !== m_duty[1]) begin
      fails++;
      $display("FAIL midframe_green: got %h expected %h", rd, m_duty[1]);
    end
  endtask

  initial begin
    test_reset();
    test_write_red();
    test_read();
    test_id_write();
    test_invalid();
    test_abort_blue();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_rgb_target.md
Name: spi_rgb_target

Overview:
- SPI mode-0 responder (target) for the board's SPI header; an external host writes and reads three 8-bit LED duty registers.
- Built-in 8-bit PWM generator drives pwm_red/green/blue, which feed the RGB LED driver PWM inputs.
- Lets power experiments set LED brightness from the host instead of from a free-running counter.
- Runs in the fabric clock domain; all SPI pins are asynchronous and oversampled.

Parameters:
- PWM_DIV, 4: fabric clocks per PWM counter step; legal range 1..255.
- ID_VALUE, 8'hA5: read-only value returned at address 3.

Ports:
- clk  input  1  fabric clock; must be at least 8x the SPI SCK frequency.
- rst  input  1  synchronous reset, active-high.
- spi_sck  input  1  SPI clock from host; idles low.
- spi_ssn  input  1  SPI chip select, active-low.
- spi_mosi  input  1  host-to-target data, MSB first.
- spi_miso  output  1  target-to-host data.
- spi_miso_oe  output  1  MISO pad output enable; 1 while ssn is synchronized low.
- pwm_red  output  1  red PWM.
- pwm_green  output  1  green PWM.
- pwm_blue  output  1  blue PWM.
- wr_strobe  output  1  one-clk pulse on each accepted register write.

Behaviour:
- Reset: all outputs are 0.
  - Duty registers and shadow duties are 0.
  - PWM counter and prescaler are 0.
  - FSM is in IDLE with the bit counter at 0.
  - Reset mid-frame aborts the frame; the rest of that frame is ignored until ssn goes high.
- Synchronization:
  - sck, ssn and mosi each pass through 2 flops.
  - A third flop on sck and on ssn provides edge detection.
  - An SCK edge is acted on 3 clks after it occurs at the pin.
- Frame: ssn low, then 8-bit command byte, then 8-bit data byte.
  - Command bit7: 1 = read, 0 = write.
  - Command bits1:0: register address. Address 0 = red duty, 1 = green duty, 2 = blue duty, 3 = ID (read-only).
  - Command bits6:2 must be 0. Any other value makes the frame invalid: no write, and reads return 8'h00.
- FSM states: IDLE, CMD, DATA, DONE.
  - IDLE -> CMD on ssn falling edge; bit counter cleared.
  - In CMD: mosi is sampled on each sck rising edge into the shift register. On the 8th rise, the command is latched, the read shifter is loaded with reg[addr] (or 00 if the frame is invalid), and the FSM moves to DATA.
  - In DATA: on each sck falling edge, spi_miso <= shifter[7] and the shifter shifts left, so the first falling edge after the 8th rise presents data bit7. mosi is sampled on each rising edge.
  - After the 8th data rise: for a valid write with addr 0..2, reg[addr] <= data on the next clk and wr_strobe pulses 1 clk. Writes to addr 3 are dropped and wr_strobe stays 0. The FSM moves to DONE.
  - In DONE: further sck edges are ignored and spi_miso holds 0.
  - In any state, an ssn rising edge returns the FSM to IDLE and spi_miso goes to 0. A partial command or partial data byte causes no register change.
  - spi_miso is 0 throughout CMD.
- PWM:
  - The prescaler counts 0..PWM_DIV-1. The 8-bit counter increments when the prescaler wraps, and itself wraps 255 -> 0.
  - pwm_x = (cnt < shadow_x), registered.
  - Shadow duties load from the duty registers only when cnt wraps to 0 (glitch-free update).
  - Duty 0 gives a constant low output; duty 255 gives high for 255 of 256 steps. The output is never constant high.
  - The PWM period is 256*PWM_DIV clks.
- Simultaneous events: a write that completes in the same clk as the PWM wrap is not visible to the shadow until the following wrap.

Test Plan:
- Reset, then idle for 2000 clks -> all pwm outputs are 0, spi_miso = 0, spi_miso_oe = 0, wr_strobe never asserts.
- Write 0x00 then 0x40 (red duty = 64), PWM_DIV = 4 -> exactly one wr_strobe pulse. From the next counter wrap, pwm_red is high for 64*4 = 256 clks in every 1024-clk period.
- Read command 0x83 -> spi_miso returns 0xA5 MSB-first, sampled on host rising edges. Read 0x80 after the previous write -> returns 0x40.
- Write 0x03 then 0x55 (ID address) -> no wr_strobe; a following read of 0x83 still returns 0xA5.
- Invalid command 0x04 then 0xFF -> no register change, no wr_strobe. Read 0x84 -> returns 0x00.
- Write 0x02 with ssn raised after 5 data bits -> blue duty unchanged. Next full write 0x02 then 0xFF -> pwm_blue high for 255 of every 256 steps.
